// File: rtl/i2cm_phy.sv
// Bit-level I2C master: executes one START, STOP, WRITE or READ bit at a time on open-drain pads,
// paced by a quarter-period divider, with clock stretching and a sticky fault flag.
module i2cm_phy (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr_n,
   input  logic [11:0] ckdiv,
   input  logic [4:0]  cmd,
   input  logic        tbit,
   output logic        rbit,
   output logic        bdone,
   output logic        error,
   input  logic        i2c_scl_i,
   input  logic        i2c_sda_i,
   output logic        i2c_scl_o,
   output logic        i2c_sda_o,
   output logic        i2c_scl_oe,
   output logic        i2c_sda_oe
);

   localparam logic [4:0] CMD_START = 5'b00001;
   localparam logic [4:0] CMD_STOP  = 5'b00010;
   localparam logic [4:0] CMD_WRITE = 5'b00100;
   localparam logic [4:0] CMD_READ  = 5'b01000;

   typedef enum logic [2:0] {IDLE, Q0, Q1, Q2, Q3, ERR} state_t;

   state_t      state, state_d;
   logic [1:0]  scl_sync, sda_sync;
   logic        scl_s, sda_s;
   logic [11:0] cnt, cnt_d, qmax;
   logic        expire, restart;
   logic [4:0]  cmd_l, cmd_l_d;
   logic        tbit_l, tbit_l_d;
   logic        scl_oe_d, sda_oe_d, bdone_d, rbit_d;

   assign i2c_scl_o = 1'b0;
   assign i2c_sda_o = 1'b0;
   assign scl_s     = scl_sync[1];
   assign sda_s     = sda_sync[1];

   // Divider clamps to a 4-cycle quarter; using >= keeps it safe if ckdiv shrinks mid-count.
   assign qmax   = (ckdiv < 12'd3) ? 12'd3 : ckdiv;
   assign expire = (cnt >= qmax);

   // Pad synchronisers idle high to match released, pulled-up lines; clr_n leaves them alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
      end else begin
         scl_sync <= {scl_sync[0], i2c_scl_i};
         sda_sync <= {sda_sync[0], i2c_sda_i};
      end
   end

   always_comb begin
      state_d  = state;
      cmd_l_d  = cmd_l;
      tbit_l_d = tbit_l;
      bdone_d  = 1'b0;
      rbit_d   = rbit;
      unique case (state)
         IDLE: begin
            if (expire && (cmd != 5'd0)) begin
               state_d  = Q0;
               cmd_l_d  = cmd;
               tbit_l_d = tbit;
            end
         end
         Q0: if (expire) state_d = Q1;
         Q1: begin
            // Slave clock stretching: hold Q1 until SCL is actually seen high.
            if (expire && scl_s) begin
               state_d = Q2;
               if (cmd_l == CMD_READ) rbit_d = sda_s;
               if ((cmd_l == CMD_WRITE) && tbit_l && !sda_s) state_d = ERR;
               if ((cmd_l == CMD_START) && !sda_s) state_d = ERR;
            end
         end
         Q2: if (expire) state_d = Q3;
         Q3: begin
            if (expire) begin
               if ((cmd_l == CMD_STOP) && !sda_s) begin
                  state_d = ERR;
               end else begin
                  state_d = IDLE;
                  bdone_d = 1'b1;
               end
            end
         end
         ERR:     state_d = ERR;
         default: state_d = IDLE;
      endcase
   end

   assign restart = (state_d != state) || bdone_d || ((state == IDLE) && expire);

   always_comb begin
      cnt_d = cnt;
      if (restart)      cnt_d = 12'd0;
      else if (!expire) cnt_d = cnt + 12'd1;
   end

   // Line drive is decoded from the next state so the pads change on the same edge as the phase.
   // IDLE holds the previous drive so SCL stays low between bits of a transfer.
   always_comb begin
      scl_oe_d = i2c_scl_oe;
      sda_oe_d = i2c_sda_oe;
      if (state_d == ERR) begin
         scl_oe_d = 1'b0;
         sda_oe_d = 1'b0;
      end else if (state_d != IDLE) begin
         unique case (cmd_l_d)
            CMD_START: begin
               scl_oe_d = (state_d == Q3);
               sda_oe_d = (state_d == Q2) || (state_d == Q3);
            end
            CMD_STOP: begin
               scl_oe_d = (state_d == Q0);
               sda_oe_d = (state_d != Q3);
            end
            CMD_WRITE: begin
               scl_oe_d = (state_d == Q0) || (state_d == Q3);
               sda_oe_d = ~tbit_l_d;
            end
            CMD_READ: begin
               scl_oe_d = (state_d == Q0) || (state_d == Q3);
               sda_oe_d = 1'b0;
            end
            default: begin
               scl_oe_d = i2c_scl_oe;
               sda_oe_d = i2c_sda_oe;
            end
         endcase
      end
   end

   // clr_n is a synchronous soft reset of everything except the synchronisers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= 12'd0;
         cmd_l      <= 5'd0;
         tbit_l     <= 1'b0;
         i2c_scl_oe <= 1'b0;
         i2c_sda_oe <= 1'b0;
         bdone      <= 1'b0;
         error      <= 1'b0;
         rbit       <= 1'b1;
      end else if (!clr_n) begin
         state      <= IDLE;
         cnt        <= 12'd0;
         cmd_l      <= 5'd0;
         tbit_l     <= 1'b0;
         i2c_scl_oe <= 1'b0;
         i2c_sda_oe <= 1'b0;
         bdone      <= 1'b0;
         error      <= 1'b0;
         rbit       <= 1'b1;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         cmd_l      <= cmd_l_d;
         tbit_l     <= tbit_l_d;
         i2c_scl_oe <= scl_oe_d;
         i2c_sda_oe <= sda_oe_d;
         bdone      <= bdone_d;
         error      <= (state_d == ERR);
         rbit       <= rbit_d;
      end
   end

endmodule

// File: tb/tb_i2cm_phy.sv
// Directed bench for i2cm_phy: pull-ups and a simple slave are modelled on the pads,
// and bus events are tracked on every falling clock edge.
module tb_i2cm_phy;

   localparam logic [4:0] CMD_START = 5'b00001;
   localparam logic [4:0] CMD_STOP  = 5'b00010;
   localparam logic [4:0] CMD_WRITE = 5'b00100;
   localparam logic [4:0] CMD_READ  = 5'b01000;

   logic        clk = 1'b0;
   logic        rst_n, clr_n;
   logic [11:0] ckdiv;
   logic [4:0]  cmd;
   logic        tbit;
   logic        rbit, bdone, error;
   logic        i2c_scl_i, i2c_sda_i, i2c_scl_o, i2c_sda_o, i2c_scl_oe, i2c_sda_oe;
   logic        stretch, sda_low;
   logic        scl_line, sda_line;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          nbdone = 0, nrise = 0, nstart = 0, nstop = 0;
   logic [8:0]  rx;

   assign scl_line  = ~i2c_scl_oe & ~stretch;
   assign sda_line  = ~i2c_sda_oe & ~sda_low;
   assign i2c_scl_i = scl_line;
   assign i2c_sda_i = sda_line;

   always #5 clk = ~clk;

   i2cm_phy dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_n      (clr_n),
      .ckdiv      (ckdiv),
      .cmd        (cmd),
      .tbit       (tbit),
      .rbit       (rbit),
      .bdone      (bdone),
      .error      (error),
      .i2c_scl_i  (i2c_scl_i),
      .i2c_sda_i  (i2c_sda_i),
      .i2c_scl_o  (i2c_scl_o),
      .i2c_sda_o  (i2c_sda_o),
      .i2c_scl_oe (i2c_scl_oe),
      .i2c_sda_oe (i2c_sda_oe)
   );

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock, observed on the falling edge; records SCL rises and START/STOP conditions.
   task automatic tick();
      logic scl_prev, sda_prev;
      scl_prev = scl_line;
      sda_prev = sda_line;
      @(negedge clk);
      cyc++;
      if (bdone) nbdone++;
      if (scl_line && !scl_prev) begin
         nrise++;
         rx = {rx[7:0], sda_line};
      end
      if (scl_line && scl_prev && sda_prev && !sda_line) nstart++;
      if (scl_line && scl_prev && !sda_prev && sda_line) nstop++;
   endtask

   task automatic waitBdone(input int maxc, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!bdone && n < maxc);
   endtask

   // Sequencer-style bit: present cmd, wait for bdone, keep cmd stale for two more cycles.
   task automatic applyStimulus(input logic [4:0] c, input logic t, input int expN, input string tag);
      int n;
      cmd  = c;
      tbit = t;
      waitBdone(100, n);
      checkOutput(tag, 16'(n), 16'(expN));
      tick();
      checkOutput({tag, "_pulse"}, {15'd0, bdone}, 16'd0);
      tick();
   endtask

   initial begin
      int         n, m, nb0, chg;
      logic       sdaHeld;
      logic [7:0] byteVal;

      rst_n = 1'b0; clr_n = 1'b1; ckdiv = 12'd3; cmd = CMD_START; tbit = 1'b0;
      stretch = 1'b0; sda_low = 1'b0; rx = '0;
      repeat (3) @(negedge clk);
      checkOutput("rst_scl_oe", {15'd0, i2c_scl_oe}, 16'd0);
      checkOutput("rst_sda_oe", {15'd0, i2c_sda_oe}, 16'd0);
      checkOutput("rst_pad_o",  {14'd0, i2c_scl_o, i2c_sda_o}, 16'd0);
      checkOutput("rst_bdone",  {15'd0, bdone}, 16'd0);
      checkOutput("rst_error",  {15'd0, error}, 16'd0);
      checkOutput("rst_rbit",   {15'd0, rbit}, 16'd1);

      // START from idle with cmd held through reset release
      rst_n = 1'b1;
      nstart = 0;
      waitBdone(60, n);
      checkOutput("start_bdone_time", 16'(n), 16'd20);
      checkOutput("start_scl_low", {15'd0, scl_line}, 16'd0);
      checkOutput("start_cond", 16'(nstart), 16'd1);
      tick();
      checkOutput("start_pulse", {15'd0, bdone}, 16'd0);
      tick();

      // Byte 0xA5 then ACK read with slave driving 0
      nrise = 0; nstart = 0; nstop = 0; rx = '0;
      byteVal = 8'hA5;
      for (int i = 7; i >= 0; i--) applyStimulus(CMD_WRITE, byteVal[i], 18, "byte_pitch");
      sda_low = 1'b1;
      applyStimulus(CMD_READ, 1'b0, 18, "ack_pitch");
      sda_low = 1'b0;
      checkOutput("ack_rbit", {15'd0, rbit}, 16'd0);
      checkOutput("byte_scl_pulses", 16'(nrise), 16'd9);
      checkOutput("byte_bits", {7'd0, rx}, 16'h014A);
      checkOutput("byte_sda_stable", 16'(nstart + nstop), 16'd0);

      // Clock stretch on a WRITE 0 bit
      applyStimulus(CMD_WRITE, 1'b1, 18, "pre_stretch");
      cmd = CMD_WRITE; tbit = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (i2c_scl_oe && n < 40);
      checkOutput("stretch_q1_entry", 16'(n), 16'd6);
      stretch = 1'b1;
      sdaHeld = i2c_sda_oe;
      chg = 0;
      repeat (29) begin
         tick();
         n++;
         if (i2c_sda_oe !== sdaHeld) chg++;
      end
      stretch = 1'b0;
      checkOutput("stretch_sda", 16'(chg), 16'd0);
      waitBdone(100, m);
      n += m;
      checkOutput("stretch_bdone_time", 16'(n), 16'd46);
      tick();
      tick();

      // STOP after a bit with SCL low
      nstop = 0;
      applyStimulus(CMD_STOP, 1'b0, 18, "stop_pitch");
      checkOutput("stop_cond", 16'(nstop), 16'd1);
      checkOutput("stop_bus_free", {14'd0, scl_line, sda_line}, 16'd3);
      checkOutput("stop_error", {15'd0, error}, 16'd0);

      // STOP with SDA stuck low
      sda_low = 1'b1;
      cmd = CMD_STOP;
      nb0 = nbdone;
      n = 0;
      do begin
         tick();
         n++;
      end while (!error && n < 40);
      cmd = 5'd0;
      checkOutput("stop_err_time", 16'(n), 16'd18);
      checkOutput("stop_err_oe", {14'd0, i2c_scl_oe, i2c_sda_oe}, 16'd0);
      repeat (8) tick();
      checkOutput("err_sticky", {15'd0, error}, 16'd1);
      checkOutput("stop_err_nobdone", 16'(nbdone - nb0), 16'd0);

      // Soft clear, then arbitration loss on WRITE 1
      clr_n = 1'b0;
      tick();
      checkOutput("clr_error", {15'd0, error}, 16'd0);
      checkOutput("clr_rbit", {15'd0, rbit}, 16'd1);
      clr_n = 1'b1;
      cmd = CMD_WRITE; tbit = 1'b1;
      nb0 = nbdone;
      n = 0;
      do begin
         tick();
         n++;
      end while (!error && n < 40);
      checkOutput("arb_err_time", 16'(n), 16'd12);
      checkOutput("arb_err_oe", {14'd0, i2c_scl_oe, i2c_sda_oe}, 16'd0);
      repeat (10) tick();
      checkOutput("arb_nobdone", 16'(nbdone - nb0), 16'd0);

      // Clear, then a normal START
      clr_n = 1'b0;
      tick();
      clr_n = 1'b1;
      sda_low = 1'b0;
      cmd = CMD_START;
      waitBdone(60, n);
      checkOutput("clr_start_time", 16'(n), 16'd20);
      checkOutput("clr_start_error", {15'd0, error}, 16'd0);
      tick();
      tick();

      // Reset pulsed during Q2 of a READ
      sda_low = 1'b1;
      cmd = CMD_READ;
      repeat (10) tick();
      checkOutput("read_q2_rbit", {15'd0, rbit}, 16'd0);
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_rbit", {15'd0, rbit}, 16'd1);
      checkOutput("async_rst_oe", {14'd0, i2c_scl_oe, i2c_sda_oe}, 16'd0);
      checkOutput("async_rst_flags", {14'd0, bdone, error}, 16'd0);
      tick();
      rst_n = 1'b1;
      sda_low = 1'b0;
      waitBdone(60, n);
      checkOutput("rst_read_bdone_time", 16'(n), 16'd20);
      checkOutput("rst_read_rbit", {15'd0, rbit}, 16'd1);
      cmd = 5'd0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
